// File: rtl/led_ctrl_pkg.sv
// Shared encodings and pattern helpers for the LED mode controller.
// Mode/speed enums plus the pure next-state functions used by the FSM.
package led_ctrl_pkg;

    localparam int CNT_W = 25;
    localparam logic [3:0] PAT_RST = 4'b0001;

    typedef enum logic [1:0] {
        RUN_L = 2'd0,
        RUN_R = 2'd1,
        BLINK = 2'd2,
        HOLD  = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        SPD_0 = 2'd0,
        SPD_1 = 2'd1,
        SPD_2 = 2'd2,
        SPD_X = 2'd3
    } speed_t;

    function automatic mode_t next_mode(input mode_t m);
        case (m)
            RUN_L:   return RUN_R;
            RUN_R:   return BLINK;
            BLINK:   return HOLD;
            default: return RUN_L;
        endcase
    endfunction

    // SPD_X is never produced but falls back to the slowest speed
    function automatic speed_t next_speed(input speed_t s);
        case (s)
            SPD_0:   return SPD_1;
            SPD_1:   return SPD_2;
            default: return SPD_0;
        endcase
    endfunction

    function automatic logic [3:0] entry_pat(input mode_t m,
                                             input logic [3:0] p);
        case (m)
            RUN_L:   return 4'b0001;
            RUN_R:   return 4'b1000;
            BLINK:   return 4'b1111;
            default: return p;
        endcase
    endfunction

    function automatic logic [3:0] step_pat(input mode_t m,
                                            input logic [3:0] p);
        case (m)
            RUN_L:   return {p[2:0], p[3]};
            RUN_R:   return {p[0], p[3:1]};
            BLINK:   return ~p;
            default: return p;
        endcase
    endfunction

endpackage

// File: rtl/led_mode_ctrl_tick.sv
// Programmable tick generator: one registered tick every limit+1 cycles.
// A clear restarts the count and suppresses the tick on that edge.
import led_ctrl_pkg::*;

module led_tick_gen (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [CNT_W-1:0] limit,
    input  logic             clear,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clear) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt >= limit) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/led_mode_ctrl.sv
// LED mode controller: mode/speed FSM driven by key pulses and a
// pattern register stepped by the tick generator.
import led_ctrl_pkg::*;

module led_mode_ctrl #(
    parameter logic [CNT_W-1:0] CNT_MAX_S0 = 25'd24_999_999,
    parameter logic [CNT_W-1:0] CNT_MAX_S1 = 25'd12_499_999,
    parameter logic [CNT_W-1:0] CNT_MAX_S2 = 25'd6_249_999
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       key_mode,
    input  logic       key_speed,
    output logic [3:0] led_out,
    output logic [1:0] mode,
    output logic [1:0] speed
);

    mode_t            state, state_nxt;
    speed_t           spd, spd_nxt;
    logic [3:0]       pat, pat_nxt;
    logic [CNT_W-1:0] limit;
    logic             tick;
    logic             key_any;

    assign key_any = key_mode | key_speed;

    always_comb begin
        case (spd)
            SPD_1:   limit = CNT_MAX_S1;
            SPD_2:   limit = CNT_MAX_S2;
            default: limit = CNT_MAX_S0;
        endcase
    end

    led_tick_gen u_tick (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .limit   (limit),
        .clear   (key_any),
        .tick    (tick)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= RUN_L;
            spd   <= SPD_0;
            pat   <= PAT_RST;
        end else begin
            state <= state_nxt;
            spd   <= spd_nxt;
            pat   <= pat_nxt;
        end
    end

    // any key pulse discards a coincident tick step
    always_comb begin
        state_nxt = state;
        spd_nxt   = spd;
        pat_nxt   = pat;
        if (key_speed)
            spd_nxt = next_speed(spd);
        if (key_mode) begin
            state_nxt = next_mode(state);
            pat_nxt   = entry_pat(state_nxt, pat);
        end else if (!key_speed && tick) begin
            pat_nxt = step_pat(state, pat);
        end
    end

    assign led_out = ~pat;
    assign mode    = state;
    assign speed   = spd;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Self-checking bench for led_mode_ctrl with short tick limits.
// Reference model feeds a per-cycle scoreboard plus directed checks.
module tb_led_mode_ctrl;

    logic       sys_clk;
    logic       sys_rst;
    logic       key_mode;
    logic       key_speed;
    logic [3:0] led_out;
    logic [1:0] mode;
    logic [1:0] speed;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] sb_q[$];

    logic [1:0] m_mode;
    logic [1:0] m_spd;
    logic [3:0] m_pat;
    logic       m_tick;
    int         m_cnt;

    led_mode_ctrl #(
        .CNT_MAX_S0 (25'd9),
        .CNT_MAX_S1 (25'd4),
        .CNT_MAX_S2 (25'd1)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .key_mode  (key_mode),
        .key_speed (key_speed),
        .led_out   (led_out),
        .mode      (mode),
        .speed     (speed)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic int lim_of(input logic [1:0] s);
        if (s == 2'd1) return 4;
        if (s == 2'd2) return 1;
        return 9;
    endfunction

    task automatic model_step(input logic km, input logic ks,
                              input logic rs);
        int lim;
        logic [1:0] nm;
        if (rs) begin
            m_mode = 2'd0; m_spd = 2'd0; m_pat = 4'b0001;
            m_cnt = 0; m_tick = 1'b0;
            return;
        end
        if (km) begin
            nm = m_mode + 2'd1;
            if (nm == 2'd0) m_pat = 4'b0001;
            else if (nm == 2'd1) m_pat = 4'b1000;
            else if (nm == 2'd2) m_pat = 4'b1111;
            m_mode = nm;
        end else if (!ks && m_tick) begin
            if (m_mode == 2'd0) m_pat = {m_pat[2:0], m_pat[3]};
            else if (m_mode == 2'd1) m_pat = {m_pat[0], m_pat[3:1]};
            else if (m_mode == 2'd2) m_pat = ~m_pat;
        end
        lim = lim_of(m_spd);
        if (km || ks) begin
            m_cnt = 0; m_tick = 1'b0;
        end else if (m_cnt >= lim) begin
            m_cnt = 0; m_tick = 1'b1;
        end else begin
            m_cnt++; m_tick = 1'b0;
        end
        if (ks) m_spd = (m_spd >= 2'd2) ? 2'd0 : m_spd + 2'd1;
    endtask

    task automatic cyc(input logic km, input logic ks, input logic rs);
        logic [7:0] exp;
        key_mode  = km;
        key_speed = ks;
        sys_rst   = rs;
        model_step(km, ks, rs);
        sb_q.push_back({m_mode, m_spd, ~m_pat});
        @(posedge sys_clk);
        #1;
        key_mode  = 1'b0;
        key_speed = 1'b0;
        sys_rst   = 1'b0;
        exp = sb_q.pop_front();
        chk("sb", {mode, speed, led_out}, exp);
    endtask

    task automatic wait_change(output logic [3:0] v, output int n);
        logic [3:0] prev;
        prev = led_out;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            n++;
            if (led_out !== prev) break;
        end
        v = led_out;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            n++;
            if (dut.u_tick.tick === 1'b1) break;
        end
    endtask

    logic [3:0] v;
    int         n;
    int         changes;
    logic [3:0] held;
    logic [3:0] seq26 [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    logic [3:0] seq27 [3] = '{4'b1101, 4'b1110, 4'b0111};
    logic [1:0] spd30 [3] = '{2'd1, 2'd2, 2'd0};
    int         per30 [3] = '{5, 2, 10};

    initial begin
        key_mode = 1'b0; key_speed = 1'b0; sys_rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        chk("rst_state", {mode, speed, led_out}, {2'd0, 2'd0, 4'b1110});

        // running left at speed 0
        for (int i = 0; i < 4; i++) begin
            wait_change(v, n);
            chk("runl_led", v, seq26[i]);
            if (i > 0) chk("runl_gap", n, 10);
        end

        // enter RUN_R
        cyc(1'b1, 1'b0, 1'b0);
        chk("runr_mode", mode, 2'd1);
        chk("runr_led", led_out, 4'b0111);
        wait_change(v, n);
        chk("runr_led1", v, 4'b1011);
        chk("runr_gap1", n, 11);
        for (int i = 0; i < 3; i++) begin
            wait_change(v, n);
            chk("runr_led", v, seq27[i]);
            chk("runr_gap", n, 10);
        end

        // BLINK then HOLD
        cyc(1'b1, 1'b0, 1'b0);
        chk("blink_mode", mode, 2'd2);
        chk("blink_led", led_out, 4'b0000);
        wait_change(v, n);
        chk("blink_led1", v, 4'b1111);
        wait_change(v, n);
        chk("blink_led2", v, 4'b0000);
        chk("blink_gap", n, 10);
        cyc(1'b1, 1'b0, 1'b0);
        chk("hold_mode", mode, 2'd3);
        held = led_out;
        chk("hold_led", held, 4'b0000);
        changes = 0;
        for (int i = 0; i < 50; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            if (led_out !== held) changes++;
        end
        chk("hold_frozen", changes, 0);

        // both keys on a tick cycle
        for (int i = 0; i < 20; i++) begin
            if (m_tick) break;
            cyc(1'b0, 1'b0, 1'b0);
        end
        chk("coin_tick", dut.u_tick.tick, 1'b1);
        cyc(1'b1, 1'b1, 1'b0);
        chk("coin_state", {mode, speed, led_out}, {2'd0, 2'd1, 4'b1110});
        wait_tick(n);
        chk("coin_next", n, 5);
        cyc(1'b0, 1'b0, 1'b0);
        chk("coin_step", led_out, 4'b1101);

        // speed sweep from reset
        cyc(1'b0, 1'b0, 1'b1);
        chk("rst2_state", {mode, speed, led_out}, {2'd0, 2'd0, 4'b1110});
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b0);
            chk("spd_val", speed, spd30[i]);
            wait_tick(n);
            chk("spd_first", n, per30[i]);
            wait_tick(n);
            chk("spd_period", n, per30[i]);
        end

        // reset mid-run in RUN_R at speed 2, keys pressed too
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("pre_rst", {mode, speed}, {2'd1, 2'd2});
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        chk("rst3_state", {mode, speed, led_out}, {2'd0, 2'd0, 4'b1110});
        wait_tick(n);
        chk("rst3_tick", n, 10);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
